// File: rtl/serial_rx_ctrl.sv
// Serial bus slave receive controller: start-bit detect, header/data segmenting of the
// serial_parallel deserializer, address decode, ack slot and register-side strobes.
// Optional feature macro: SERIAL_RX_BROADCAST_EN (all-ones header address also matches writes).
module serial_rx_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned PORT_WIDTH = 14,
  parameter int unsigned BIT_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  bus_in,
  input  logic [ADDR_WIDTH-1:0] my_addr,
  input  logic [PORT_WIDTH-1:0] sp_dout,
  input  logic                  sp_dv,
  output logic                  sp_en,
  output logic [BIT_LENGTH-1:0] sp_bit_lngth,
  output logic                  ack_out,
  output logic [ADDR_WIDTH-1:0] rx_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_valid,
  output logic                  rd_req,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned HDR_LEN = ADDR_WIDTH + 1;
  localparam int unsigned DAT_LEN = DATA_WIDTH;
  localparam logic [BIT_LENGTH-1:0] HDR_BL   = BIT_LENGTH'(HDR_LEN);
  localparam logic [BIT_LENGTH-1:0] DAT_BL   = BIT_LENGTH'(DAT_LEN);
  localparam logic [BIT_LENGTH-1:0] HDR_LAST = BIT_LENGTH'(HDR_LEN - 1);
  localparam logic [BIT_LENGTH-1:0] DAT_LAST = BIT_LENGTH'(DAT_LEN - 1);
  localparam logic [BIT_LENGTH-1:0] DAT_END  = BIT_LENGTH'(DAT_LEN);

  typedef enum logic [2:0] {IDLE, HDR, DEC, ACK, DATA, SKIP} state_t;

  state_t                state_q, state_d;
  logic [BIT_LENGTH-1:0] cnt_q, cnt_d;
  logic                  wr_hit_q, wr_hit_d;
  logic                  sp_en_d, ack_d, wr_valid_d, rd_req_d, busy_d, err_d;
  logic [BIT_LENGTH-1:0] bl_d;
  logic [ADDR_WIDTH-1:0] rx_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic                  hdr_rd;
  logic                  hdr_match;

  // Header decode straight off the deserializer word
  always_comb begin
    hdr_addr = sp_dout[HDR_LEN-1:1];
    hdr_rd   = sp_dout[0];
`ifdef SERIAL_RX_BROADCAST_EN
    hdr_match = (hdr_addr == my_addr) || ((hdr_addr == {ADDR_WIDTH{1'b1}}) && !hdr_rd);
`else
    hdr_match = (hdr_addr == my_addr);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_hit_q     <= 1'b0;
      sp_en        <= 1'b0;
      sp_bit_lngth <= HDR_BL;
      ack_out      <= 1'b0;
      rx_addr      <= '0;
      wr_data      <= '0;
      wr_valid     <= 1'b0;
      rd_req       <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_hit_q     <= wr_hit_d;
      sp_en        <= sp_en_d;
      sp_bit_lngth <= bl_d;
      ack_out      <= ack_d;
      rx_addr      <= rx_addr_d;
      wr_data      <= wr_data_d;
      wr_valid     <= wr_valid_d;
      rd_req       <= rd_req_d;
      busy         <= busy_d;
      err          <= err_d;
    end
  end

  // The counter times every state; sp_dv only confirms the expected word boundaries
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + BIT_LENGTH'(1);
    wr_hit_d   = wr_hit_q;
    sp_en_d    = sp_en;
    bl_d       = sp_bit_lngth;
    busy_d     = busy;
    rx_addr_d  = rx_addr;
    wr_data_d  = wr_data;
    ack_d      = 1'b0;
    rd_req_d   = 1'b0;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus_in) begin
          state_d = HDR;
          sp_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      HDR: begin
        if (sp_dv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == HDR_LAST) begin
          state_d = DEC;
          sp_en_d = 1'b0;
        end
      end
      DEC: begin
        if (!sp_dv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d   = ACK;
          rx_addr_d = hdr_addr;
          ack_d     = hdr_match;
          rd_req_d  = hdr_match && hdr_rd;
          wr_hit_d  = hdr_match && !hdr_rd;
        end
      end
      ACK: begin
        if (sp_dv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = '0;
          bl_d  = DAT_BL;
          if (wr_hit_q) begin
            state_d = DATA;
            sp_en_d = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      DATA: begin
        if (cnt_q == DAT_END) begin
          if (sp_dv) begin
            wr_data_d  = sp_dout[DATA_WIDTH-1:0];
            wr_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sp_dv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == DAT_LAST) begin
          sp_en_d = 1'b0;
        end
      end
      SKIP: begin
        if (sp_dv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == DAT_END) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts silently: no strobes, no error, no register updates
    if (!en) begin
      state_d    = IDLE;
      ack_d      = 1'b0;
      rd_req_d   = 1'b0;
      wr_valid_d = 1'b0;
      err_d      = 1'b0;
      rx_addr_d  = rx_addr;
      wr_data_d  = wr_data;
    end

    if (state_d == IDLE) begin
      cnt_d   = '0;
      sp_en_d = 1'b0;
      busy_d  = 1'b0;
      bl_d    = HDR_BL;
    end
  end

endmodule
